spi_cmd_seq: RTL and testbench

SPI_CMD_SEQ -- requirements
Module: spi_cmd_seq

---
 rtl/spi_seq_pkg.sv | 31 +++
 rtl/spi_seq_fifo.sv | 59 +++++
 rtl/spi_cmd_seq.sv | 186 ++++++++++++++++++
 tb/tb_spi_cmd_seq.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_seq_pkg.sv
// Shared definitions for the SPI command sequencer: FIFO entry type codes,
// sequencer state encodings and the bit positions inside spi_control.
package spi_seq_pkg;

    localparam int ENTRY_W        = 10;
    localparam int CTRL_W         = 10;
    localparam int CTRL_ENABLE    = 0;
    localparam int CTRL_DATA_MODE = 1;
    localparam int CTRL_PRESC_LSB = 2;
    localparam int CTRL_PRESC_MSB = 9;

    typedef enum logic [1:0] {
        ENTRY_CMD   = 2'b00,
        ENTRY_DATA  = 2'b01,
        ENTRY_DELAY = 2'b10,
        ENTRY_RSVD  = 2'b11
    } entry_type_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_XFER  = 3'd2,
        ST_GAP   = 3'd3,
        ST_DELAY = 3'd4
    } seq_state_e;

    function automatic entry_type_e entry_type(input logic [ENTRY_W-1:0] entry);
        return entry_type_e'(entry[ENTRY_W-1:ENTRY_W-2]);
    endfunction

endpackage

// File: rtl/spi_seq_fifo.sv
// Command FIFO for the SPI sequencer: DEPTH entries (power of two), first-word
// fall-through head, occupancy count one bit wider than the pointers.
module spi_seq_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is dropped even when a pop happens in the same cycle.
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/spi_cmd_seq.sv
// SPI command sequencer: drains a FIFO of cmd/data/delay entries into an SPI TX
// engine, bursting consecutive data bytes. Optional delay entries: SPI_CMD_SEQ_DELAY_EN.
module spi_cmd_seq
    import spi_seq_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int GAP_CYCLES  = 2,
    parameter int DELAY_TICKS = 50000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               wr_en,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic [7:0]         prescaler,
    output logic               full,
    output logic               empty,
    output logic               overflow,
    output logic               busy,
    output logic [CTRL_W-1:0]  spi_control,
    output logic [7:0]         spi_data,
    input  logic               spi_valid
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    seq_state_e          state_q, state_d;
    entry_type_e         cur_type_q, cur_type_d;
    logic [7:0]          cur_byte_q, cur_byte_d;
    logic                enable_q, enable_d;
    logic                mode_q, mode_d;
    logic [7:0]          data_q, data_d;
    logic [7:0]          presc_q;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic                overflow_q;

    logic                fifo_pop;
    logic [ENTRY_W-1:0]  fifo_head;
    logic                fifo_full;
    logic                fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                head_is_data;

`ifdef SPI_CMD_SEQ_DELAY_EN
    logic [31:0]         delay_cnt_q, delay_cnt_d;
`endif

    spi_seq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // A burst may only continue if the next queued entry is already present and is data.
    assign head_is_data = (fifo_count != '0) && (entry_type(fifo_head) == ENTRY_DATA);

    always_comb begin
        state_d    = state_q;
        cur_type_d = cur_type_q;
        cur_byte_d = cur_byte_q;
        enable_d   = enable_q;
        mode_d     = mode_q;
        data_d     = data_q;
        gap_cnt_d  = gap_cnt_q;
        fifo_pop   = 1'b0;
`ifdef SPI_CMD_SEQ_DELAY_EN
        delay_cnt_d = delay_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    cur_type_d = entry_type(fifo_head);
                    cur_byte_d = fifo_head[7:0];
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                case (cur_type_q)
                    ENTRY_CMD, ENTRY_DATA: begin
                        data_d   = cur_byte_q;
                        mode_d   = (cur_type_q == ENTRY_DATA);
                        enable_d = 1'b1;
                        state_d  = ST_XFER;
                    end
`ifdef SPI_CMD_SEQ_DELAY_EN
                    ENTRY_DELAY: begin
                        delay_cnt_d = 32'(cur_byte_q) * 32'(DELAY_TICKS);
                        state_d     = ST_DELAY;
                    end
`endif
                    default: state_d = ST_IDLE;
                endcase
            end
            ST_XFER: begin
                if (spi_valid) begin
                    if ((cur_type_q == ENTRY_DATA) && head_is_data) begin
                        fifo_pop   = 1'b1;
                        cur_byte_d = fifo_head[7:0];
                        data_d     = fifo_head[7:0];
                    end else begin
                        enable_d  = 1'b0;
                        gap_cnt_d = '0;
                        state_d   = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
`ifdef SPI_CMD_SEQ_DELAY_EN
            // A zero count still spends one cycle here before returning to IDLE.
            ST_DELAY: begin
                if (delay_cnt_q <= 32'd1) begin
                    delay_cnt_d = '0;
                    state_d     = ST_IDLE;
                end else begin
                    delay_cnt_d = delay_cnt_q - 32'd1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cur_type_q <= ENTRY_CMD;
            cur_byte_q <= '0;
            enable_q   <= 1'b0;
            mode_q     <= 1'b0;
            data_q     <= '0;
            presc_q    <= '0;
            gap_cnt_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_type_q <= cur_type_d;
            cur_byte_q <= cur_byte_d;
            enable_q   <= enable_d;
            mode_q     <= mode_d;
            data_q     <= data_d;
            presc_q    <= prescaler;
            gap_cnt_q  <= gap_cnt_d;
            overflow_q <= overflow_q | (wr_en & fifo_full);
        end
    end

`ifdef SPI_CMD_SEQ_DELAY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            delay_cnt_q <= '0;
        end else begin
            delay_cnt_q <= delay_cnt_d;
        end
    end
`endif

    assign full     = fifo_full;
    assign empty    = fifo_empty;
    assign overflow = overflow_q;
    assign busy     = (state_q != ST_IDLE);
    assign spi_data = data_q;

    always_comb begin
        spi_control                                = '0;
        spi_control[CTRL_ENABLE]                   = enable_q;
        spi_control[CTRL_DATA_MODE]                = mode_q;
        spi_control[CTRL_PRESC_MSB:CTRL_PRESC_LSB] = presc_q;
    end

endmodule

// File: tb/tb_spi_cmd_seq.sv
// Self-checking bench for spi_cmd_seq: random and directed entry streams are
// compared against a transaction-level model of which bytes go out in which CS window.
module tb_spi_cmd_seq;

    localparam int DEPTH       = 16;
    localparam int GAP_CYCLES  = 2;
    localparam int DELAY_TICKS = 10;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [9:0] wr_data = '0;
    logic [7:0] prescaler = '0;
    logic       spi_valid = 1'b0;
    logic       full, empty, overflow, busy;
    logic [9:0] spi_control;
    logic [7:0] spi_data;

    spi_cmd_seq #(
        .DEPTH       (DEPTH),
        .GAP_CYCLES  (GAP_CYCLES),
        .DELAY_TICKS (DELAY_TICKS)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .prescaler   (prescaler),
        .full        (full),
        .empty       (empty),
        .overflow    (overflow),
        .busy        (busy),
        .spi_control (spi_control),
        .spi_data    (spi_data),
        .spi_valid   (spi_valid)
    );

    always #5 clk = ~clk;

    int testsRun = 0;
    int failCount = 0;

    logic [9:0]  pushQ[$];
    logic [31:0] expQ[$];
    int  modelTxn = 0;
    int  dutTxn = 0;
    bit  prevWasData = 0;
    bit  prevEn = 0, prevBusy = 0, fallArmed = 0, haveTxn = 0;
    bit  prescValid = 0, responderHold = 0;
    int  sinceFall = 0, lowRun = 0, waitCnt = 0, waitTarget = 12, fixedDelay = 0;
    int  cycle = 0, lastRiseCycle = 0, delayPushCycle = 0;
    logic [7:0] lastPresc = '0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    function automatic logic [31:0] packXfer(input int txn, input logic mode, input logic [7:0] b);
        logic [15:0] t;
        t = txn[15:0];
        return {t, 7'd0, mode, b};
    endfunction

    // Model: every cmd is its own CS window; a run of adjacent data entries shares one
    // window; reserved and delay entries emit nothing and break a data run.
    task automatic addEntry(input logic [1:0] t, input logic [7:0] b, input bit accepted);
        pushQ.push_back({t, b});
        if (accepted) begin
            if (t == 2'b00) begin
                modelTxn++;
                expQ.push_back(packXfer(modelTxn, 1'b0, b));
                prevWasData = 0;
            end else if (t == 2'b01) begin
                if (!prevWasData) modelTxn++;
                expQ.push_back(packXfer(modelTxn, 1'b1, b));
                prevWasData = 1;
            end else begin
                prevWasData = 0;
            end
        end
    endtask

    task automatic addRandomEntry(input bit accepted);
        int r;
        logic [1:0] t;
        logic [7:0] b;
        r = $urandom_range(19, 0);
        t = (r < 8) ? 2'b01 : (r < 13) ? 2'b00 : (r < 16) ? 2'b11 : 2'b10;
        b = (t == 2'b10) ? 8'($urandom_range(3, 0)) : 8'($urandom);
        addEntry(t, b, accepted);
    endtask

    task automatic newScenario();
        prevWasData = 0;
        fixedDelay  = 0;
    endtask

    // One clock: sample outputs #1 after the edge, update monitors, then drive inputs.
    task automatic applyStimulus();
        bit en;
        logic [7:0] p;
        @(posedge clk);
        #1;
        cycle++;
        en = spi_control[0];
        if (prescValid) checkOutput("prescaler", 32'(spi_control[9:2]), 32'(lastPresc));
        if (en && !prevEn) begin
            dutTxn++;
            lastRiseCycle = cycle;
            if (haveTxn) checkOutput("gap_low", 32'(lowRun >= GAP_CYCLES), 1);
            haveTxn    = 1;
            fallArmed  = 0;
            waitCnt    = 0;
            lowRun     = 0;
            waitTarget = (fixedDelay > 0) ? fixedDelay : int'($urandom_range(16, 10));
        end
        if (!en && prevEn) begin
            fallArmed = 1;
            sinceFall = 0;
        end else if (fallArmed) begin
            sinceFall++;
        end
        if (!en) lowRun++;
        if (prevBusy && !busy && fallArmed) begin
            checkOutput("gap_to_idle", sinceFall, GAP_CYCLES);
            fallArmed = 0;
        end

        if (pushQ.size() > 0) begin
            wr_en   = 1'b1;
            wr_data = pushQ.pop_front();
            if (wr_data[9:8] == 2'b10) delayPushCycle = cycle;
        end else begin
            wr_en = 1'b0;
        end

        spi_valid = 1'b0;
        if (en) begin
            if (!responderHold) begin
                waitCnt++;
                if (waitCnt >= waitTarget) begin
                    spi_valid  = 1'b1;
                    waitCnt    = 0;
                    waitTarget = (fixedDelay > 0) ? fixedDelay : int'($urandom_range(16, 10));
                    checkOutput("exp_avail", 32'(expQ.size() > 0), 1);
                    if (expQ.size() > 0)
                        checkOutput("xfer", packXfer(dutTxn, spi_control[1], spi_data), expQ.pop_front());
                end
            end
        end else begin
            spi_valid = ($urandom_range(3, 0) == 0);
        end

        p          = 8'($urandom);
        prescaler  = p;
        lastPresc  = p;
        prescValid = 1;
        prevEn     = en;
        prevBusy   = busy;
    endtask

    task automatic runUntilIdle(input int budget);
        int n;
        bit done;
        n = 0;
        done = 0;
        while (!done && n < budget) begin
            applyStimulus();
            n++;
            done = (pushQ.size() == 0) && (expQ.size() == 0) && !busy && empty && (n > 3);
        end
        checkOutput("drain_done", 32'(done), 1);
    endtask

    initial begin
        int n;
        int lat;
        int txnBefore;

        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst0_ctrl", 32'(spi_control), 0);
        checkOutput("rst0_data", 32'(spi_data), 0);
        checkOutput("rst0_empty", 32'(empty), 1);
        checkOutput("rst0_full", 32'(full), 0);
        checkOutput("rst0_ovf", 32'(overflow), 0);
        checkOutput("rst0_busy", 32'(busy), 0);
        reset_n = 1'b1;
        repeat (3) applyStimulus();

        // Single command with a slow responder.
        newScenario();
        fixedDelay = 20;
        addEntry(2'b00, 8'hAE, 1);
        runUntilIdle(300);
        checkOutput("cmd_empty", 32'(empty), 1);

        // Data burst followed by a command.
        newScenario();
        addEntry(2'b01, 8'h11, 1);
        addEntry(2'b01, 8'h22, 1);
        addEntry(2'b01, 8'h33, 1);
        addEntry(2'b00, 8'h5A, 1);
        runUntilIdle(500);

        // Reserved entry produces no window; following data goes out in data mode.
        newScenario();
        addEntry(2'b11, 8'hC3, 1);
        addEntry(2'b01, 8'h7F, 1);
        runUntilIdle(300);

        // Delay entry ahead of a command.
        newScenario();
        addEntry(2'b10, 8'd3, 1);
        addEntry(2'b00, 8'h01, 1);
        runUntilIdle(500);
        lat = lastRiseCycle - delayPushCycle;
`ifdef SPI_CMD_SEQ_DELAY_EN
        checkOutput("delay_wait", 32'((lat >= 3 * DELAY_TICKS) && (lat <= 3 * DELAY_TICKS + 10)), 1);
`else
        checkOutput("no_delay", 32'(lat <= 10), 1);
`endif

        for (int s = 0; s < 20; s++) begin
            newScenario();
            n = $urandom_range(8, 1);
            for (int i = 0; i < n; i++) addRandomEntry(1);
            runUntilIdle(3000);
            checkOutput("rand_empty", 32'(empty), 1);
            checkOutput("rand_full", 32'(full), 0);
            checkOutput("rand_ovf", 32'(overflow), 0);
        end

        // Overflow while the sequencer is stalled waiting for spi_valid.
        newScenario();
        responderHold = 1;
        addEntry(2'b00, 8'h42, 1);
        n = 0;
        while (!spi_control[0] && n < 50) begin
            applyStimulus();
            n++;
        end
        checkOutput("ovf_blocked", 32'(spi_control[0]), 1);
        for (int i = 0; i < DEPTH; i++) addRandomEntry(1);
        while (pushQ.size() > 0) applyStimulus();
        applyStimulus();
        checkOutput("full_at_16", 32'(full), 1);
        checkOutput("ovf_at_16", 32'(overflow), 0);
        addRandomEntry(0);
        applyStimulus();
        applyStimulus();
        checkOutput("ovf_at_17", 32'(overflow), 1);
        checkOutput("full_at_17", 32'(full), 1);
        responderHold = 0;
        runUntilIdle(6000);
        checkOutput("ovf_sticky", 32'(overflow), 1);

        // Reset in the middle of a data burst.
        newScenario();
        for (int i = 0; i < 5; i++) addEntry(2'b01, 8'($urandom), 1);
        n = 0;
        while (expQ.size() > 3 && n < 500) begin
            applyStimulus();
            n++;
        end
        checkOutput("burst_progress", 32'(expQ.size() <= 3), 1);
        checkOutput("burst_enable", 32'(spi_control[0]), 1);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("rst_ctrl", 32'(spi_control), 0);
        checkOutput("rst_data", 32'(spi_data), 0);
        checkOutput("rst_empty", 32'(empty), 1);
        checkOutput("rst_full", 32'(full), 0);
        checkOutput("rst_ovf", 32'(overflow), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        pushQ.delete();
        expQ.delete();
        wr_en     = 1'b0;
        spi_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        prevEn     = 0;
        prevBusy   = 0;
        fallArmed  = 0;
        haveTxn    = 0;
        prescValid = 0;
        txnBefore  = dutTxn;
        repeat (30) applyStimulus();
        checkOutput("post_rst_txn", dutTxn, txnBefore);
        checkOutput("post_rst_busy", 32'(busy), 0);
        checkOutput("post_rst_empty", 32'(empty), 1);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
